// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the LED fade output stage.
// Holds the ramp state encoding and the duty ceiling helper.

package led_fade_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_t;

    // Full-scale duty for a given PWM width (2^bits - 1).
    function automatic int unsigned duty_max(
        input int unsigned bits
    );
        if (bits >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pin-side bundle of the fade driver: blink level in, PWM and status out.
// Ports: IN_LEVEL (level in), LED (PWM out), DUTY (duty), BUSY (ramping).

interface led_fade_driver_if #(
    parameter int PWM_BITS = 8
);

    logic                IN_LEVEL;
    logic                LED;
    logic [PWM_BITS-1:0] DUTY;
    logic                BUSY;

    // master: the environment driving the level and watching the pin
    modport master (
        output IN_LEVEL,
        input  LED,
        input  DUTY,
        input  BUSY
    );

    // slave: the fade driver itself
    modport slave (
        input  IN_LEVEL,
        output LED,
        output DUTY,
        output BUSY
    );

endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with a registered duty compare.
// Ports: CLK, RST (sync, active-high), DUTY (in), LED (registered out).

module led_pwm_gen
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [PWM_BITS-1:0] DUTY,
    output logic                LED
);

    localparam logic [PWM_BITS-1:0] DMAX =
        PWM_BITS'(duty_max(PWM_BITS));

    logic [PWM_BITS-1:0] pcnt;

    // Full scale is forced solid; the plain compare would
    // drop one cycle per period at DUTY == MAX.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt <= '0;
            LED  <= 1'b0;
        end else begin
            pcnt <= pcnt + 1'b1;
            LED  <= (DUTY == DMAX) | (pcnt < DUTY);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// Fades the board LED up/down following the blink generator level.
// Ports: CLK, RST (sync, active-high), io (slave: IN_LEVEL, LED, DUTY, BUSY).

module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 50000
) (
    input  logic                 CLK,
    input  logic                 RST,
    led_fade_driver_if.slave     io
);

    localparam int SW = $clog2(STEP_CYCLES);

    localparam logic [SW-1:0] SLAST =
        SW'(STEP_CYCLES - 1);

    localparam logic [PWM_BITS-1:0] DMAX =
        PWM_BITS'(duty_max(PWM_BITS));

    logic                s1;
    logic                s2;
    logic                lvl;
    logic [SW-1:0]       scnt;
    logic                step;
    fade_state_t         state;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS:0]   duty_inc;
    logic                led_q;

    // Two-flop synchroniser for the asynchronous blink level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= io.IN_LEVEL;
            s2 <= s1;
        end
    end

    assign lvl = s2;

    // Free-running step prescaler, never re-phased by the level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scnt <= '0;
        end else if (scnt == SLAST) begin
            scnt <= '0;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    assign step     = (scnt == SLAST);
    assign duty_inc = {1'b0, duty} + 1'b1;

    // Ramp FSM. A level reversal always beats a step.
    // A reversal right after an end point leaves UP at MAX
    // or DOWN at 0; the next step then only settles the
    // state, so DUTY never wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_OFF;
            duty  <= '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    if (lvl) begin
                        state <= ST_UP;
                    end
                end
                ST_UP: begin
                    if (!lvl) begin
                        state <= ST_DOWN;
                    end else if (step) begin
                        if (duty == DMAX) begin
                            state <= ST_ON;
                        end else begin
                            duty <= duty_inc[PWM_BITS-1:0];
                            if (duty_inc == {1'b0, DMAX}) begin
                                state <= ST_ON;
                            end
                        end
                    end
                end
                ST_ON: begin
                    if (!lvl) begin
                        state <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (lvl) begin
                        state <= ST_UP;
                    end else if (step) begin
                        if (duty == '0) begin
                            state <= ST_OFF;
                        end else begin
                            duty <= duty - 1'b1;
                            if (duty == PWM_BITS'(1)) begin
                                state <= ST_OFF;
                            end
                        end
                    end
                end
            endcase
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .CLK  (CLK),
        .RST  (RST),
        .DUTY (duty),
        .LED  (led_q)
    );

    assign io.LED  = led_q;
    assign io.DUTY = duty;
    assign io.BUSY = (state == ST_UP) | (state == ST_DOWN);

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage between the blink generator and the board LED pin: it consumes the generator's square-wave level (the `OUT` net, currently wired straight to `LED`) and drives the pin with a PWM signal that ramps brightness linearly up on a rising level and down on a falling level ("fade" blinking). It synchronises the incoming level, runs a 4-state ramp FSM paced by a step prescaler, and produces a registered PWM output plus status.

## Interface
- `PWM_BITS`, default 8: PWM counter and duty width; `MAX = 2^PWM_BITS-1`.
- `STEP_CYCLES`, default 50000: clock cycles per duty step, ≥2; full ramp = `MAX*STEP_CYCLES` cycles.
- `CLK`  in  1  single clock; all logic rising-edge.
- `RST`  in  1  reset, synchronous, active-high.
- `IN_LEVEL`  in  1  blink level from the generator; asynchronous to the ramp logic, so it is synchronised.
- `LED`  out  1  registered PWM drive to the pin.
- `DUTY`  out  `PWM_BITS`  current duty register.
- `BUSY`  out  1  high while ramping (state UP or DOWN).

## Operation
- Sync: `IN_LEVEL` → `s1` → `s2` (2 flops); `lvl = s2`. No debounce.
- Step prescaler: `scnt` counts `0..STEP_CYCLES-1` and wraps to 0, free-running; `step = (scnt == STEP_CYCLES-1)`.
- PWM counter: `pcnt`, `PWM_BITS` wide, increments every cycle and wraps `MAX` → 0.
- PWM compare: `LED <= (DUTY == MAX) | (pcnt < DUTY)`.
  - `DUTY=0` gives constant 0.
  - `DUTY=MAX` gives constant 1.
  - Otherwise high for `DUTY` of every `2^PWM_BITS` cycles.
- FSM (states OFF, UP, ON, DOWN). Level check has priority over step:
  - OFF: if `lvl`, go to UP.
  - UP:
    - if `!lvl`, go to DOWN; `DUTY` unchanged this cycle.
    - else on `step`, `DUTY <= DUTY+1`; if `DUTY+1 == MAX`, go to ON on the same edge.
  - ON: if `!lvl`, go to DOWN.
  - DOWN:
    - if `lvl`, go to UP; `DUTY` unchanged this cycle.
    - else on `step`, `DUTY <= DUTY-1`; if `DUTY-1 == 0`, go to OFF on the same edge.
  - Mid-ramp reversal continues from the current `DUTY`; there is no jump.
- Arithmetic: `DUTY` never wraps. It is held in `[0,MAX]` by the state rules (UP never steps at `MAX`, DOWN never steps at 0). The `PWM_BITS+1`-bit compare for `DUTY+1` needs no overflow logic.
- `BUSY = (state==UP) | (state==DOWN)`, combinational from the state register.
- Reset (any cycle, including mid-ramp), next edge:
  - state OFF; `DUTY=0`; `LED=0`; `BUSY=0`.
  - `s1=s2=0`; `scnt=0`; `pcnt=0`.

## Timing
- `IN_LEVEL` high before edge k: `s1` at k, `s2` at k+1, state UP at k+2. Level-to-FSM latency is 2 edges, to `BUSY` 2 edges.
- First `DUTY` increment occurs on the first `step` at or after edge k+3. This phase is not aligned to the input; `scnt` is not reset by level changes.
- `LED` lags `DUTY`/`pcnt` by 1 register.
- Steady ON: `LED` constant 1 starting one edge after `DUTY` reaches `MAX`.
- Input toggling faster than the ramp: the FSM alternates UP/DOWN with `DUTY` oscillating near its current value. This is correct behaviour, not an error.
- `step` coinciding with a level reversal: the reversal wins and no duty change occurs that cycle.

## Structure
- Package `led_fade_pkg`:
  - state encoding: OFF=2'd0, UP=2'd1, ON=2'd2, DOWN=2'd3;
  - function `duty_max(PWM_BITS)`.
- Sub-module `led_pwm_gen` (params `PWM_BITS`; ports `CLK`, `RST`, `DUTY`, `LED`) holds `pcnt` and the registered compare.
- Top `led_fade_driver` holds the synchroniser, prescaler and FSM; it is instantiated between the generator's `OUT` and the top-level `LED` port.

## Test plan
All scenarios use `PWM_BITS=3` and `STEP_CYCLES=4` (`MAX=7`).
- Reset: assert `RST` 3 cycles mid-ramp at `DUTY=4`, state UP → next edge `DUTY=0`, `LED=0`, `BUSY=0`; after release with `IN_LEVEL=0`, `LED` stays 0 for 64 cycles.
- Full rise: `IN_LEVEL` 0→1 and held → state UP 2 edges later. `DUTY` goes 1,2,…,7 at 4-cycle spacing (≤31 cycles total). State ON and `BUSY` low when `DUTY=7`; then `LED` constant 1.
- PWM shape: hold a mid-ramp level by forcing `DUTY=3` via a sequence, or check during the UP dwell → `LED` high for exactly 3 of each 8 `pcnt` cycles, 1 cycle after compare.
- Full fall: from ON, `IN_LEVEL` 1→0 → DOWN 2 edges later. `DUTY` 6,5,…,0 every 4 cycles, then OFF, `BUSY=0`, `LED` constant 0.
- Reversal: drop `IN_LEVEL` when `DUTY=4` in UP, including one run where `lvl` falls on a `step` edge → DOWN with `DUTY` still 4 on that edge; next `step` gives `DUTY=3`.
- Glitch: 1-cycle `IN_LEVEL` pulse in OFF → if captured, UP for ≥1 cycle then DOWN/OFF with `DUTY` ≤1; no X and no wrap below 0.
